// File: rtl/emailbox_drain.sv
// emailbox_drain: drains the emesh mailbox through its register read port.
// Each message is a STAT / LO / HI read sequence. The {hi, lo} word is then
// offered on a valid/ready stream, and delivered messages are counted.
module emailbox_drain #(
    parameter int          AW        = 32,
    parameter logic [31:0] MBOX_BASE = 32'h0000_0000,
    parameter logic [5:0]  IDX_STAT  = 6'd0,
    parameter logic [5:0]  IDX_LO    = 6'd1,
    parameter logic [5:0]  IDX_HI    = 6'd2,
    localparam int         PW        = 2*AW+40
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          enable,
    input  logic          mailbox_irq,
    output logic          reg_access,
    output logic [PW-1:0] reg_packet,
    input  logic [31:0]   reg_rdata,
    output logic          msg_valid,
    input  logic          msg_ready,
    output logic [63:0]   msg_data,
    output logic [31:0]   last_status,
    output logic [31:0]   drain_count,
    output logic          busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] STAT_REQ  = 3'd1;
    localparam logic [2:0] STAT_WAIT = 3'd2;
    localparam logic [2:0] LO_REQ    = 3'd3;
    localparam logic [2:0] LO_WAIT   = 3'd4;
    localparam logic [2:0] HI_REQ    = 3'd5;
    localparam logic [2:0] HI_WAIT   = 3'd6;
    localparam logic [2:0] OUT       = 3'd7;

    logic [2:0] state;

    // Read packet for one mailbox word. The fixed field layout assumes AW >= 32.
    function automatic logic [PW-1:0] rd_pkt(input logic [5:0] idx);
        logic [PW-1:0] p;
        p       = '0;
        p[2:1]  = 2'b10;
        p[39:8] = {MBOX_BASE[31:8], idx, 2'b00};
        return p;
    endfunction

    // Sequencer. Each REQ state is followed by a WAIT state, so strobes are
    // never back-to-back and at most one read is outstanding. The packet is
    // loaded on entry to each REQ state and then held until the next one.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= IDLE;
            reg_packet  <= '0;
            msg_data    <= '0;
            last_status <= '0;
            drain_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && mailbox_irq) begin
                        state      <= STAT_REQ;
                        reg_packet <= rd_pkt(IDX_STAT);
                    end
                end
                STAT_REQ: state <= STAT_WAIT;
                STAT_WAIT: begin
                    last_status <= reg_rdata;
                    // An irq raised only by prog_full/full with an empty FIFO falls back to IDLE.
                    if (reg_rdata[0] && enable) begin
                        state      <= LO_REQ;
                        reg_packet <= rd_pkt(IDX_LO);
                    end else begin
                        state <= IDLE;
                    end
                end
                // The LO read pops the FIFO, so from here on the message is always delivered.
                LO_REQ: state <= LO_WAIT;
                LO_WAIT: begin
                    msg_data[31:0] <= reg_rdata;
                    state          <= HI_REQ;
                    reg_packet     <= rd_pkt(IDX_HI);
                end
                HI_REQ: state <= HI_WAIT;
                HI_WAIT: begin
                    msg_data[63:32] <= reg_rdata;
                    state           <= OUT;
                end
                OUT: begin
                    if (msg_ready) begin
                        drain_count <= drain_count + 32'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        reg_access = (state == STAT_REQ) || (state == LO_REQ) || (state == HI_REQ);
        msg_valid  = (state == OUT);
        busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_emailbox_drain.sv
// tb_emailbox_drain: directed checks of the mailbox drain sequencer, with a
// small behavioural mailbox that answers the register reads.
module tb_emailbox_drain;

    localparam int PW = 104;

    logic          clk = 1'b0;
    logic          nreset;
    logic          enable;
    logic          mailbox_irq;
    logic          reg_access;
    logic [PW-1:0] reg_packet;
    logic [31:0]   reg_rdata;
    logic          msg_valid;
    logic          msg_ready;
    logic [63:0]   msg_data;
    logic [31:0]   last_status;
    logic [31:0]   drain_count;
    logic          busy;

    emailbox_drain dut (
        .clk(clk), .nreset(nreset), .enable(enable), .mailbox_irq(mailbox_irq),
        .reg_access(reg_access), .reg_packet(reg_packet), .reg_rdata(reg_rdata),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .last_status(last_status), .drain_count(drain_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Mailbox model: the FIFO pops on the LO read, and HI returns the popped entry.
    logic [63:0] q[$];
    logic [63:0] cur = '0;
    logic        stat_ovr_en = 1'b0;
    logic [31:0] stat_ovr = '0;
    int          n_stat = 0, n_lo = 0, n_hi = 0;
    logic [5:0]  ridx;

    always @(posedge clk) begin
        if (reg_access) begin
            ridx = reg_packet[15:10];
            case (ridx)
                6'd0: begin
                    n_stat++;
                    reg_rdata <= stat_ovr_en ? stat_ovr : {31'b0, q.size() != 0};
                end
                6'd1: begin
                    n_lo++;
                    if (q.size() != 0) cur = q.pop_front();
                    reg_rdata <= cur[31:0];
                end
                6'd2: begin
                    n_hi++;
                    reg_rdata <= cur[63:32];
                end
                default: reg_rdata <= 32'hBAD0_BAD0;
            endcase
        end else begin
            reg_rdata <= 32'hDEAD_BEEF;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for msg_valid; an expired budget shows up as a failed check.
    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30 && !msg_valid; i++) step();
        check(tag, PW'(msg_valid), PW'(1));
    endtask

    task automatic do_reset();
        nreset = 1'b0; enable = 1'b0; mailbox_irq = 1'b0; msg_ready = 1'b0;
        stat_ovr_en = 1'b0;
        q.delete();
        step(); step();
        nreset = 1'b1;
    endtask

    function automatic logic [PW-1:0] exp_pkt(input logic [5:0] idx);
        logic [PW-1:0] p;
        p = '0;
        p[2:1] = 2'b10;
        p[39:8] = {24'h0, idx, 2'b00};
        return p;
    endfunction

    logic [63:0] first_msg;
    logic [63:0] rx[3];
    int          got;
    int          lo0, stat0;

    initial begin
        // ---- reset state
        do_reset();
        check("rst_access", PW'(reg_access), PW'(0));
        check("rst_valid",  PW'(msg_valid),  PW'(0));
        check("rst_busy",   PW'(busy),       PW'(0));
        check("rst_data",   PW'(msg_data),   PW'(0));
        check("rst_status", PW'(last_status), PW'(0));
        check("rst_count",  PW'(drain_count), PW'(0));

        // ---- single message, full timing
        q.push_back(64'h1122_3344_5566_7788);
        enable = 1; mailbox_irq = 1; msg_ready = 1;
        step();
        check("t1_acc_stat", PW'(reg_access), PW'(1));
        check("t1_pkt_stat", reg_packet, exp_pkt(6'd0));
        step();
        check("t2_noacc", PW'(reg_access), PW'(0));
        step();
        check("t3_acc_lo", PW'(reg_access), PW'(1));
        check("t3_pkt_lo", reg_packet, exp_pkt(6'd1));
        step();
        check("t4_noacc", PW'(reg_access), PW'(0));
        step();
        check("t5_acc_hi", PW'(reg_access), PW'(1));
        check("t5_pkt_hi", reg_packet, exp_pkt(6'd2));
        step();
        check("t6_valid0", PW'(msg_valid), PW'(0));
        step();
        check("t7_valid", PW'(msg_valid), PW'(1));
        check("t7_data", PW'(msg_data), PW'(64'h1122_3344_5566_7788));
        mailbox_irq = 0;
        step();
        check("t1_count", PW'(drain_count), PW'(1));
        check("t1_status0", PW'(last_status[0]), PW'(1));
        check("t1_idle", PW'(busy), PW'(0));

        // ---- spurious irq: prog_full only, FIFO empty
        do_reset();
        stat_ovr_en = 1; stat_ovr = 32'h0000_0004;
        lo0 = n_lo;
        enable = 1; mailbox_irq = 1; msg_ready = 1;
        step();
        mailbox_irq = 0;
        step();
        step();
        check("sp_idle", PW'(busy), PW'(0));
        check("sp_status", PW'(last_status), PW'(32'h4));
        for (int i = 0; i < 4; i++) step();
        check("sp_nolo", PW'(n_lo - lo0), PW'(0));
        check("sp_novalid", PW'(msg_valid), PW'(0));
        check("sp_count", PW'(drain_count), PW'(0));

        // ---- three entries with backpressure
        do_reset();
        q.push_back(64'hA000_0001_B000_0001);
        q.push_back(64'hA000_0002_B000_0002);
        q.push_back(64'hA000_0003_B000_0003);
        enable = 1; mailbox_irq = 1; msg_ready = 0;
        wait_valid("bp_valid");
        first_msg = msg_data;
        check("bp_first", PW'(first_msg), PW'(64'hA000_0001_B000_0001));
        stat0 = n_stat; lo0 = n_lo;
        for (int i = 0; i < 10; i++) begin
            step();
            if (msg_data !== first_msg || !msg_valid || reg_access) begin
                check("bp_stall_data", PW'(msg_data), PW'(first_msg));
                check("bp_stall_valid", PW'(msg_valid), PW'(1));
                check("bp_stall_acc", PW'(reg_access), PW'(0));
            end
        end
        check("bp_stable", PW'(msg_data), PW'(first_msg));
        check("bp_noreads", PW'(n_stat - stat0 + n_lo - lo0), PW'(0));
        msg_ready = 1;
        got = 0;
        for (int i = 0; i < 40 && got < 3; i++) begin
            if (msg_valid) begin
                rx[got] = msg_data;
                got++;
            end
            step();
        end
        mailbox_irq = 0;
        check("bp_got", PW'(got), PW'(3));
        check("bp_rx1", PW'(rx[1]), PW'(64'hA000_0002_B000_0002));
        check("bp_rx2", PW'(rx[2]), PW'(64'hA000_0003_B000_0003));
        for (int i = 0; i < 4; i++) step();
        check("bp_count", PW'(drain_count), PW'(3));

        // ---- enable dropped after LO_REQ
        do_reset();
        q.push_back(64'h0BAD_F00D_1234_5678);
        q.push_back(64'h0000_0000_0000_0099);
        enable = 1; mailbox_irq = 1; msg_ready = 1;
        step(); step(); step();
        check("en_lo_req", PW'(reg_access), PW'(1));
        enable = 0;
        step(); step(); step();
        step();
        check("en_valid", PW'(msg_valid), PW'(1));
        check("en_data", PW'(msg_data), PW'(64'h0BAD_F00D_1234_5678));
        stat0 = n_stat;
        for (int i = 0; i < 5; i++) step();
        check("en_held_idle", PW'(busy), PW'(0));
        check("en_nostat", PW'(n_stat - stat0), PW'(0));
        check("en_count", PW'(drain_count), PW'(1));
        enable = 1;
        step();
        check("en_restart", PW'(reg_access), PW'(1));
        check("en_restart_pkt", reg_packet, exp_pkt(6'd0));

        // ---- reset in HI_WAIT
        do_reset();
        q.push_back(64'h5555_6666_7777_8888);
        q.push_back(64'h9999_AAAA_BBBB_CCCC);
        enable = 1; mailbox_irq = 1; msg_ready = 1;
        for (int i = 0; i < 6; i++) step();
        check("hr_busy", PW'(busy), PW'(1));
        nreset = 0;
        step();
        check("hr_access", PW'(reg_access), PW'(0));
        check("hr_valid", PW'(msg_valid), PW'(0));
        check("hr_busy0", PW'(busy), PW'(0));
        check("hr_data", PW'(msg_data), PW'(0));
        check("hr_status", PW'(last_status), PW'(0));
        nreset = 1;
        step();
        check("hr_fresh_acc", PW'(reg_access), PW'(1));
        check("hr_fresh_pkt", reg_packet, exp_pkt(6'd0));
        mailbox_irq = 0;
        wait_valid("hr_valid2");
        check("hr_data2", PW'(msg_data), PW'(64'h9999_AAAA_BBBB_CCCC));

        // ---- drain_count wrap
        do_reset();
        q.push_back(64'h0000_0001_0000_0002);
        force dut.drain_count = 32'hFFFF_FFFF;
        step();
        release dut.drain_count;
        enable = 1; mailbox_irq = 1; msg_ready = 1;
        wait_valid("wr_valid");
        mailbox_irq = 0;
        step();
        check("wr_count", PW'(drain_count), PW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
